// File: rtl/divider.sv
// 32-bit iterative divider for the RISC-V M extension (DIV, DIVU, REM, REMU).
// Uses restoring shift-subtract on operand magnitudes, one quotient bit per
// cycle. A division by zero or a signed overflow is resolved when the request
// is accepted, and the result is presented on the following cycle.
//
// Handshake: a request on op/op1/op2 is taken at a rising edge where the
// divider is IDLE, op_valid=1 and op_stall=0. The result appears on op_out
// and is marked by op_ready, a one-cycle strobe that is high while the divider
// is in DONE and op_stall=0. The consumer takes op_out in that cycle. While
// op_stall=1 in DONE, op_ready stays low and op_out holds its value.
// op_stall does not pause iterations that are already running.

module divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_stall,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [31:0] op_out,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;

  // Operation context latched at accept.
  logic        rem_sel_q;   // 1: remainder result, 0: quotient result
  logic        neg_quot_q;  // negate the magnitude quotient at the end
  logic        neg_rem_q;   // negate the magnitude remainder at the end
  logic [31:0] divisor_q;   // divisor magnitude
  logic [31:0] quot_q;      // dividend bits shift out, quotient bits shift in
  logic [31:0] rem_q;       // partial remainder
  logic [5:0]  count_q;     // iterations left after the current one

  logic [31:0] result_q;

  // Accept-time decode.
  logic        accept;
  logic        is_signed;
  logic        is_div_group;
  logic        div_by_zero;
  logic        sgn_overflow;
  logic        resolve_now;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        neg_quot;
  logic        neg_rem;
  logic [31:0] early_result;

  // Iteration datapath.
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        take;
  logic [31:0] rem_nxt;
  logic [31:0] quot_nxt;

  // Final sign correction.
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;
  logic [31:0] final_result;

  assign state_dbg = state_q;
  assign op_out    = result_q;

  // Decode the incoming request and derive magnitudes and result signs.
  always_comb begin
    accept       = (state_q == IDLE) && op_valid && !op_stall;
    is_signed    = !op[0];
    is_div_group = op[2];
    div_by_zero  = (op2 == 32'd0);
    sgn_overflow = is_signed && (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);
    // Encodings outside the divide group are not meaningful here. They finish
    // on the next cycle with a zero result, so the FSM never stalls on them.
    resolve_now  = div_by_zero || sgn_overflow || !is_div_group;

    mag_a = (is_signed && op1[31]) ? (32'd0 - op1) : op1;
    mag_b = (is_signed && op2[31]) ? (32'd0 - op2) : op2;

    neg_quot = is_signed && (op1[31] ^ op2[31]) && !div_by_zero;
    neg_rem  = is_signed && op1[31];
  end

  // Results for the cases that skip the iteration loop.
  always_comb begin
    early_result = 32'd0;
    if (!is_div_group) begin
      early_result = 32'd0;
    end else if (div_by_zero) begin
      early_result = op[1] ? op1 : 32'hFFFF_FFFF;
    end else if (sgn_overflow) begin
      early_result = op[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One restoring shift-subtract step. The subtraction is one bit wider than
  // the operands, so bit 32 of diff is the borrow and means "does not fit".
  always_comb begin
    shifted  = {rem_q, quot_q[31]};
    diff     = shifted - {1'b0, divisor_q};
    take     = !diff[32];
    rem_nxt  = take ? diff[31:0] : shifted[31:0];
    quot_nxt = {quot_q[30:0], take};
  end

  // Restore the signs on the final step and select quotient or remainder.
  always_comb begin
    quot_fix     = neg_quot_q ? (32'd0 - quot_nxt) : quot_nxt;
    rem_fix      = neg_rem_q  ? (32'd0 - rem_nxt)  : rem_nxt;
    final_result = rem_sel_q ? rem_fix : quot_fix;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and the completion strobe.
  always_comb begin
    state_d  = state_q;
    op_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = resolve_now ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (count_q == 6'd0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!op_stall) begin
          op_ready = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand capture, iteration registers and the result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_sel_q  <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      divisor_q  <= 32'd0;
      quot_q     <= 32'd0;
      rem_q      <= 32'd0;
      count_q    <= 6'd0;
      result_q   <= 32'd0;
    end else begin
      if (accept) begin
        rem_sel_q  <= op[1];
        neg_quot_q <= neg_quot;
        neg_rem_q  <= neg_rem;
        divisor_q  <= mag_b;
        quot_q     <= mag_a;
        rem_q      <= 32'd0;
        count_q    <= 6'd31;
        if (resolve_now) begin
          result_q <= early_result;
          count_q  <= 6'd0;
        end
      end else if (state_q == BUSY) begin
        rem_q  <= rem_nxt;
        quot_q <= quot_nxt;
        if (count_q == 6'd0) begin
          result_q <= final_result;
        end else begin
          count_q <= count_q - 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed testbench for the divider: signed, unsigned and early-resolved
// cases, stall behaviour, back-to-back requests and reset during an operation.

module tb_divider;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_stall;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] op_out;
  logic [1:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  divider dut (
    .clk       (clk),
    .rst       (rst),
    .op_stall  (op_stall),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op        (op),
    .op1       (op1),
    .op2       (op2),
    .op_out    (op_out),
    .state_dbg (state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  // Driver: present one request, wait for op_ready (bounded), then look one
  // cycle further. lat counts clocks from the accept edge to the ready cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res,
                        output logic rdy_after, output logic [1:0] st_after);
    @(negedge clk);
    op = o; op1 = a; op2 = b; op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!op_ready && lat < 100);
    res = op_out;
    @(negedge clk);
    rdy_after = op_ready;
    st_after  = state_dbg;
  endtask

  task automatic test_reset();
    rst = 1'b1; op_stall = 1'b0; op_valid = 1'b1; op = OP_DIV;
    op1 = 32'd9; op2 = 32'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, S_IDLE); end
    checks++;
    if (op_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", op_ready); end
    checks++;
    if (op_out !== 32'd0) begin errors++; $display("FAIL reset_out got=%h exp=0", op_out); end
    op_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_signed();
    logic [2:0]  vo [6];
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [31:0] ve [6];
    int lat; logic [31:0] res; logic rdy; logic [1:0] st;
    vo = '{OP_DIV, OP_REM, OP_DIV, OP_REM, OP_REM, OP_DIV};
    va = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'hFFFFFF9C, 32'hFFFFFF9C};
    vb = '{32'd2, 32'd2, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9};
    ve = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF2, 32'd2, 32'hFFFFFFFE, 32'd14};
    for (int i = 0; i < 6; i++) begin
      run_op(vo[i], va[i], vb[i], lat, res, rdy, st);
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL signed_lat[%0d] got=%0d exp=33", i, lat); end
      checks++;
      if (res !== ve[i]) begin errors++; $display("FAIL signed_out[%0d] got=%h exp=%h", i, res, ve[i]); end
      checks++;
      if (rdy !== 1'b0) begin errors++; $display("FAIL signed_pulse[%0d] got=%b exp=0", i, rdy); end
      checks++;
      if (st !== S_IDLE) begin errors++; $display("FAIL signed_idle[%0d] got=%0d exp=%0d", i, st, S_IDLE); end
    end
  endtask

  task automatic test_unsigned();
    logic [2:0]  vo [5];
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [31:0] ve [5];
    int lat; logic [31:0] res; logic rdy; logic [1:0] st;
    vo = '{OP_DIVU, OP_REMU, OP_DIVU, OP_REMU, OP_DIVU};
    va = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h12345678};
    vb = '{32'h10, 32'h10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1};
    ve = '{32'h0FFFFFFF, 32'h0000000F, 32'd0, 32'h80000000, 32'h12345678};
    for (int i = 0; i < 5; i++) begin
      run_op(vo[i], va[i], vb[i], lat, res, rdy, st);
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL unsigned_lat[%0d] got=%0d exp=33", i, lat); end
      checks++;
      if (res !== ve[i]) begin errors++; $display("FAIL unsigned_out[%0d] got=%h exp=%h", i, res, ve[i]); end
      checks++;
      if (rdy !== 1'b0) begin errors++; $display("FAIL unsigned_pulse[%0d] got=%b exp=0", i, rdy); end
      checks++;
      if (st !== S_IDLE) begin errors++; $display("FAIL unsigned_idle[%0d] got=%0d exp=%0d", i, st, S_IDLE); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  vo [6];
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [31:0] ve [6];
    int lat; logic [31:0] res; logic rdy; logic [1:0] st;
    vo = '{OP_DIV, OP_REMU, OP_DIV, OP_REM, OP_REM, OP_DIVU};
    va = '{32'd5, 32'h12345678, 32'h80000000, 32'h80000000, 32'hFFFFFFFB, 32'd0};
    vb = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
    ve = '{32'hFFFFFFFF, 32'h12345678, 32'h80000000, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF};
    for (int i = 0; i < 6; i++) begin
      run_op(vo[i], va[i], vb[i], lat, res, rdy, st);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL special_lat[%0d] got=%0d exp=1", i, lat); end
      checks++;
      if (res !== ve[i]) begin errors++; $display("FAIL special_out[%0d] got=%h exp=%h", i, res, ve[i]); end
      checks++;
      if (rdy !== 1'b0) begin errors++; $display("FAIL special_pulse[%0d] got=%b exp=0", i, rdy); end
      checks++;
      if (st !== S_IDLE) begin errors++; $display("FAIL special_idle[%0d] got=%0d exp=%0d", i, st, S_IDLE); end
    end
  endtask

  // DIVU 1000/3 = 333; stall held over cycles 20..40 after accept.
  task automatic test_stall();
    @(negedge clk);
    op = OP_DIVU; op1 = 32'd1000; op2 = 32'd3; op_valid = 1'b1; op_stall = 1'b0;
    @(posedge clk);
    #1;
    for (int n = 1; n <= 42; n++) begin
      @(negedge clk);
      if (n == 20) op_stall = 1'b1;
      if (n == 41) op_stall = 1'b0;
      if (n == 33) op_valid = 1'b0;
      #1;
      if (n <= 40) begin
        checks++;
        if (op_ready !== 1'b0) begin errors++; $display("FAIL stall_no_ready[c%0d] got=%b exp=0", n, op_ready); end
      end
      if (n >= 2 && n <= 32) begin
        checks++;
        if (state_dbg !== S_BUSY) begin errors++; $display("FAIL stall_busy[c%0d] got=%0d exp=%0d", n, state_dbg, S_BUSY); end
      end
      if (n >= 33 && n <= 40) begin
        checks++;
        if (state_dbg !== S_DONE) begin errors++; $display("FAIL stall_done[c%0d] got=%0d exp=%0d", n, state_dbg, S_DONE); end
        checks++;
        if (op_out !== 32'd333) begin errors++; $display("FAIL stall_hold[c%0d] got=%h exp=%h", n, op_out, 32'd333); end
      end
      if (n == 41) begin
        checks++;
        if (op_ready !== 1'b1) begin errors++; $display("FAIL stall_release got=%b exp=1", op_ready); end
        checks++;
        if (op_out !== 32'd333) begin errors++; $display("FAIL stall_out got=%h exp=%h", op_out, 32'd333); end
      end
      if (n == 42) begin
        checks++;
        if (op_ready !== 1'b0) begin errors++; $display("FAIL stall_pulse got=%b exp=0", op_ready); end
        checks++;
        if (state_dbg !== S_IDLE) begin errors++; $display("FAIL stall_idle got=%0d exp=%0d", state_dbg, S_IDLE); end
      end
    end
  endtask

  // op_valid held continuously: 100/7 then 200/7; operands changed mid-BUSY
  // must be ignored and no accept may happen in the ready cycle.
  task automatic test_back_to_back();
    logic exp_rdy;
    @(negedge clk);
    op = OP_DIVU; op1 = 32'd100; op2 = 32'd7; op_valid = 1'b1; op_stall = 1'b0;
    @(posedge clk);
    #1;
    for (int n = 1; n <= 68; n++) begin
      @(negedge clk);
      if (n == 5)  op1 = 32'hDEADBEEF;
      if (n == 34) op1 = 32'd200;
      if (n == 36) op_valid = 1'b0;
      #1;
      exp_rdy = (n == 33) || (n == 67);
      checks++;
      if (op_ready !== exp_rdy) begin errors++; $display("FAIL b2b_ready[c%0d] got=%b exp=%b", n, op_ready, exp_rdy); end
      if (n == 33) begin
        checks++;
        if (op_out !== 32'd14) begin errors++; $display("FAIL b2b_out1 got=%h exp=%h", op_out, 32'd14); end
      end
      if (n == 34) begin
        checks++;
        if (state_dbg !== S_IDLE) begin errors++; $display("FAIL b2b_gap got=%0d exp=%0d", state_dbg, S_IDLE); end
      end
      if (n == 35) begin
        checks++;
        if (state_dbg !== S_BUSY) begin errors++; $display("FAIL b2b_reaccept got=%0d exp=%0d", state_dbg, S_BUSY); end
      end
      if (n == 67) begin
        checks++;
        if (op_out !== 32'd28) begin errors++; $display("FAIL b2b_out2 got=%h exp=%h", op_out, 32'd28); end
      end
    end
  endtask

  // Reset at clock 10 of BUSY, then a new request in the first cycle after.
  task automatic test_reset_mid_op();
    int lat;
    @(negedge clk);
    op = OP_REM; op1 = 32'hFFFFFF9C; op2 = 32'd7; op_valid = 1'b1; op_stall = 1'b0;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    for (int n = 1; n <= 10; n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    op = OP_DIVU; op1 = 32'd100; op2 = 32'd7; op_valid = 1'b1;
    #1;
    checks++;
    if (state_dbg !== S_IDLE) begin errors++; $display("FAIL midrst_state got=%0d exp=%0d", state_dbg, S_IDLE); end
    checks++;
    if (op_out !== 32'd0) begin errors++; $display("FAIL midrst_out got=%h exp=0", op_out); end
    checks++;
    if (op_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b exp=0", op_ready); end
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!op_ready && lat < 100);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL midrst_lat got=%0d exp=33", lat); end
    checks++;
    if (op_out !== 32'd14) begin errors++; $display("FAIL midrst_result got=%h exp=%h", op_out, 32'd14); end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_special();
    test_stall();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
